// File: rtl/ref_row_fetcher.sv
`default_nettype none
// ============================================================================
//  Module      : ref_row_fetcher
//  Description : Fetches a NUM_ROWS x ROW_PIX reference window from 64-bit
//                frame memory (8 pixels/word), aligns each row to the window
//                x position and hands it out on a valid/ready interface.
//  Revision    : 1.0 - initial release
// ============================================================================
module ref_row_fetcher #(
   parameter int PIXEL_W       = 8,
   parameter int ROW_PIX       = 15,
   parameter int NUM_ROWS      = 15,
   parameter int FRAME_W_WORDS = 240,
   parameter int ADDR_W        = 16
) (
   input  logic                       clk,
   input  logic                       rst,        // asynchronous, active-low
   input  logic                       start,
   input  logic [15:0]                blk_x,
   input  logic [15:0]                blk_y,
   output logic                       busy,
   output logic                       mem_rd,
   output logic [ADDR_W-1:0]          mem_addr,
   input  logic [63:0]                mem_rdata,
   output logic [ROW_PIX*PIXEL_W-1:0] row_out,
   output logic                       row_valid,
   input  logic                       row_ready,
   output logic [3:0]                 row_idx,
   output logic                       done
);

   localparam int         c_ROW_W    = ROW_PIX * PIXEL_W;
   localparam logic [3:0] c_LAST_ROW = 4'(NUM_ROWS - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_LAST  = 2'd2,
      S_HOLD  = 2'd3
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;

   logic [2:0]           r_off;       // pixel offset of the window inside word 0
   logic [ADDR_W-1:0]    r_base;      // word address of the current row's first word
   logic                 r_nw3;       // row spans three words (offset >= 2)
   logic [1:0]           r_rd_cnt;    // reads issued so far for the current row
   logic [63:0]          r_w0;
   logic [63:0]          r_w1;
   logic [c_ROW_W-1:0]   r_row_out;
   logic                 r_row_valid;
   logic [3:0]           r_row_idx;
   logic                 r_done;

   logic [ADDR_W-1:0]    w_start_base;
   logic                 w_last_rd;
   logic [191:0]         w_cat;
   logic [c_ROW_W-1:0]   w_row;

   // Window origin in words; the product wraps to the address width.
   assign w_start_base = ADDR_W'(32'(blk_y) * 32'(FRAME_W_WORDS) + 32'(blk_x[15:3]));

   // Final read of the row is the second word, or the third when it straddles.
   assign w_last_rd = (r_rd_cnt == (r_nw3 ? 2'd2 : 2'd1));

   // The last word is taken straight from the memory bus; an unused third word reads as zero.
   assign w_cat = r_nw3 ? {mem_rdata, r_w1, r_w0} : {64'd0, mem_rdata, r_w0};
   assign w_row = c_ROW_W'(w_cat >> {r_off, 3'b000});

   assign busy      = (r_state != S_IDLE);
   assign row_out   = r_row_out;
   assign row_valid = r_row_valid;
   assign row_idx   = r_row_idx;
   assign done      = r_done;

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode and memory read strobe/address.
   always_comb begin
      w_state_nxt = r_state;
      mem_rd      = 1'b0;
      mem_addr    = '0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt = S_FETCH;
            end
         end
         S_FETCH: begin
            mem_rd   = 1'b1;
            mem_addr = r_base + ADDR_W'(r_rd_cnt);
            if (w_last_rd) begin
               w_state_nxt = S_LAST;
            end
         end
         S_LAST: begin
            w_state_nxt = S_HOLD;
         end
         S_HOLD: begin
            if (row_ready) begin
               w_state_nxt = (r_row_idx == c_LAST_ROW) ? S_IDLE : S_FETCH;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Window parameters, word capture, row alignment and row handshake.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_off       <= '0;
         r_base      <= '0;
         r_nw3       <= 1'b0;
         r_rd_cnt    <= '0;
         r_w0        <= '0;
         r_w1        <= '0;
         r_row_out   <= '0;
         r_row_valid <= 1'b0;
         r_row_idx   <= '0;
         r_done      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_off     <= blk_x[2:0];
                  r_base    <= w_start_base;
                  r_nw3     <= (blk_x[2:1] != 2'b00);
                  r_rd_cnt  <= '0;
                  r_row_idx <= '0;
               end
            end
            S_FETCH: begin
               r_rd_cnt <= r_rd_cnt + 2'd1;
               // Data on the bus belongs to the read issued one cycle earlier.
               if (r_rd_cnt == 2'd1) begin
                  r_w0 <= mem_rdata;
               end
               if (r_rd_cnt == 2'd2) begin
                  r_w1 <= mem_rdata;
               end
            end
            S_LAST: begin
               r_row_out   <= w_row;
               r_row_valid <= 1'b1;
            end
            S_HOLD: begin
               if (row_ready) begin
                  r_row_valid <= 1'b0;
                  r_rd_cnt    <= '0;
                  if (r_row_idx == c_LAST_ROW) begin
                     r_done    <= 1'b1;
                     r_row_idx <= '0;
                  end else begin
                     r_row_idx <= r_row_idx + 4'd1;
                     r_base    <= r_base + ADDR_W'(FRAME_W_WORDS);
                  end
               end
            end
            default: begin
               r_row_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ref_row_fetcher.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ref_row_fetcher
//  Description : Scoreboard bench for ref_row_fetcher on a 32-pixel-wide frame
//                where pixel(x,y) = (x + 32y) mod 256.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ref_row_fetcher;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [15:0]  blk_x;
   logic [15:0]  blk_y;
   logic         busy;
   logic         mem_rd;
   logic [15:0]  mem_addr;
   logic [63:0]  mem_rdata;
   logic [119:0] row_out;
   logic         row_valid;
   logic         row_ready;
   logic [3:0]   row_idx;
   logic         done;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int last_rd_cyc = 0;
   int done_cnt = 0;
   logic prev_valid = 1'b0;

   logic [15:0]  exp_addr_q[$];
   logic [119:0] exp_row_q[$];
   logic [3:0]   exp_idx_q[$];

   ref_row_fetcher #(
      .PIXEL_W      (8),
      .ROW_PIX      (15),
      .NUM_ROWS     (15),
      .FRAME_W_WORDS(4),
      .ADDR_W       (16)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .blk_x    (blk_x),
      .blk_y    (blk_y),
      .busy     (busy),
      .mem_rd   (mem_rd),
      .mem_addr (mem_addr),
      .mem_rdata(mem_rdata),
      .row_out  (row_out),
      .row_valid(row_valid),
      .row_ready(row_ready),
      .row_idx  (row_idx),
      .done     (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Word a holds pixels 8a..8a+7 of the linear frame, so pixel k = (8a+k) mod 256.
   function automatic logic [63:0] mem_word(input logic [15:0] a);
      logic [63:0] w;
      for (int k = 0; k < 8; k++) w[8*k +: 8] = 8'((int'(a) * 8 + k) & 255);
      return w;
   endfunction

   // One-cycle-latency memory; idle cycles drive a recognisable junk pattern.
   always @(posedge clk) mem_rdata <= mem_rd ? mem_word(mem_addr) : 64'hA5A5_A5A5_A5A5_A5A5;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: compares every read address and every row transfer against the queues.
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            if (mem_rd) begin
               if (exp_addr_q.size() == 0) begin
                  tests++; fails++;
                  $display("FAIL rd_unexpected: got addr %0d expected no read", mem_addr);
               end else begin
                  chk("rd_addr", 128'(mem_addr), 128'(exp_addr_q.pop_front()));
               end
               last_rd_cyc = cyc;
            end
            if (row_valid) chk("no_rd_while_valid", 128'(mem_rd), 128'(0));
            if (row_valid && !prev_valid) chk("valid_latency", 128'(cyc - last_rd_cyc), 128'(2));
            if (row_valid && row_ready) begin
               if (exp_row_q.size() == 0) begin
                  tests++; fails++;
                  $display("FAIL row_unexpected: got idx %0d expected no row", row_idx);
               end else begin
                  chk("row_data", 128'(row_out), 128'(exp_row_q.pop_front()));
                  chk("row_idx", 128'(row_idx), 128'(exp_idx_q.pop_front()));
               end
            end
            if (done) begin
               done_cnt++;
               chk("busy_at_done", 128'(busy), 128'(0));
            end
         end
         prev_valid = row_valid;
      end
   end

   // Push the expected read addresses and aligned rows of a whole window.
   task automatic push_window(input int bx, input int by);
      int nw;
      logic [119:0] row;
      nw = ((bx % 8) <= 1) ? 2 : 3;
      for (int r = 0; r < 15; r++) begin
         for (int j = 0; j < nw; j++) exp_addr_q.push_back(16'(((by + r) * 4 + bx / 8 + j) & 16'hFFFF));
         for (int k = 0; k < 15; k++) row[8*k +: 8] = 8'((bx + k + 32 * (by + r)) & 255);
         exp_row_q.push_back(row);
         exp_idx_q.push_back(4'(r));
      end
   endtask

   // Run one window; p0/p14 are the hand-computed first and last pixels of row 0.
   task automatic run_window(input int bx, input int by, input int p0, input int p14,
                             input bit stall, input bit inject);
      int  d0;
      bit  first_seen;
      bit  stalled;
      logic [119:0] snap;
      first_seen = 1'b0;
      stalled    = 1'b0;
      push_window(bx, by);
      d0 = done_cnt;
      blk_x = 16'(bx); blk_y = 16'(by); start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 3000 && done_cnt == d0; i++) begin
         if (inject && i == 30) begin
            start = 1'b1; blk_x = 16'd24; blk_y = 16'd1;
         end else begin
            start = 1'b0;
         end
         if (!first_seen && row_valid) begin
            first_seen = 1'b1;
            chk("row0_pix0", 128'(row_out[7:0]), 128'(p0));
            chk("row0_pix14", 128'(row_out[119:112]), 128'(p14));
            chk("row0_idx", 128'(row_idx), 128'(0));
         end
         if (stall && !stalled && row_valid && row_idx == 4'd3) begin
            stalled = 1'b1;
            row_ready = 1'b0;
            snap = row_out;
            repeat (10) begin
               @(negedge clk);
               chk("stall_valid", 128'(row_valid), 128'(1));
               chk("stall_idx", 128'(row_idx), 128'(3));
               chk("stall_row", 128'(row_out), 128'(snap));
            end
            @(posedge clk); #1;
            row_ready = 1'b1;
            @(negedge clk);
            chk("xfer_cycle_no_rd", 128'(mem_rd), 128'(0));
            @(negedge clk);
            chk("row4_rd_start", 128'(mem_rd), 128'(1));
            chk("row4_rd_addr", 128'(mem_addr), 128'(16));
            chk("row4_idx", 128'(row_idx), 128'(4));
         end
         @(posedge clk); #1;
      end
      start = 1'b0;
      if (done_cnt == d0) begin
         tests++; fails++;
         $display("FAIL window_timeout: got no done expected done for x=%0d y=%0d", bx, by);
      end
      repeat (3) @(posedge clk);
      #1;
      chk("done_once", 128'(done_cnt - d0), 128'(1));
      chk("idle_busy", 128'(busy), 128'(0));
      chk("addr_q_empty", 128'(exp_addr_q.size()), 128'(0));
      chk("row_q_empty", 128'(exp_row_q.size()), 128'(0));
      exp_addr_q.delete();
      exp_row_q.delete();
      exp_idx_q.delete();
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; blk_x = '0; blk_y = '0; row_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 128'(busy), 128'(0));
      chk("rst_mem_rd", 128'(mem_rd), 128'(0));
      chk("rst_mem_addr", 128'(mem_addr), 128'(0));
      chk("rst_row_valid", 128'(row_valid), 128'(0));
      chk("rst_row_out", 128'(row_out), 128'(0));
      chk("rst_row_idx", 128'(row_idx), 128'(0));
      chk("rst_done", 128'(done), 128'(0));
      rst = 1'b1;
      @(posedge clk); #1;

      run_window(16, 2, 80, 94, 1'b0, 1'b0);    // aligned
      run_window(5, 0, 5, 19, 1'b0, 1'b0);      // three-word row
      run_window(9, 0, 9, 23, 1'b0, 1'b0);      // offset 1, two words
      run_window(0, 0, 0, 14, 1'b1, 1'b0);      // backpressure on row 3
      run_window(3, 4, 131, 145, 1'b0, 1'b1);   // start while busy

      // Reset during the second read of row 0.
      exp_addr_q.push_back(16'd10);
      blk_x = 16'd16; blk_y = 16'd2; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("mid_rst_mem_rd", 128'(mem_rd), 128'(0));
      chk("mid_rst_busy", 128'(busy), 128'(0));
      chk("mid_rst_row_valid", 128'(row_valid), 128'(0));
      chk("mid_rst_row_out", 128'(row_out), 128'(0));
      chk("mid_rst_addr_q", 128'(exp_addr_q.size()), 128'(0));
      exp_addr_q.delete();
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      run_window(16, 2, 80, 94, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ref_row_fetcher.md
Name: ref_row_fetcher

Overview:
Row source feeding the subpixel interpolator's 120-bit `in_row` input. It reads a 15x15 pixel reference window from frame memory. Memory is 64-bit words, 8 pixels per word, and the window may start at any pixel x. The block aligns each window row and presents it as 15 packed pixels on a valid/ready handshake. `row_ready` is driven by the interpolator's row-load enable.

Parameters:
PIXEL_W, 8, bits per pixel (fixed; 8 pixels per memory word)
ROW_PIX, 15, pixels per output row (8 block + 7 filter taps)
NUM_ROWS, 15, rows per window
FRAME_W_WORDS, 240, frame width in 64-bit words (row pitch)
ADDR_W, 16, memory word-address width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
start  in  1  one-cycle pulse; begin window fetch
blk_x  in  16  pixel x of window top-left
blk_y  in  16  pixel y of window top-left
busy  out  1  high from the cycle after an accepted start until done
mem_rd  out  1  memory read strobe
mem_addr  out  ADDR_W  word address, valid with mem_rd
mem_rdata  in  64  read data, valid the cycle after mem_rd; pixel k at [8k+:8]
row_out  out  120  aligned row; pixel k at [8k+:8]
row_valid  out  1  row_out holds a complete row
row_ready  in  1  consumer accepts row_out
row_idx  out  4  index (0..NUM_ROWS-1) of the row on row_out
done  out  1  one-cycle pulse after the final row transfer

Behaviour:
- Reset (rst=0, async): state IDLE. busy, mem_rd, row_valid and done = 0. mem_addr, row_out and row_idx = 0. All internal word registers = 0.
- start is accepted only in IDLE. While busy it is ignored, with no effect on the current fetch.
- On acceptance, latch:
  - off = blk_x[2:0]
  - base = blk_y*FRAME_W_WORDS + (blk_x>>3), truncated mod 2^ADDR_W
  - nw = 2 if off<=1, else 3
- Window in-frame guarantee: the caller keeps the window inside the frame. No edge padding or clipping is performed.
- FSM states: IDLE, FETCH, LAST, HOLD.
- IDLE -> FETCH on an accepted start. busy=1 from the next cycle.
- FETCH:
  - mem_rd=1 for nw consecutive cycles.
  - mem_addr = base+0, base+1 (, base+2).
  - Each mem_rdata is captured into word register w0/w1/w2 the cycle after its read.
  - After the last read issues -> LAST (mem_rd=0).
- LAST: the final word arrives on mem_rdata.
  - row_out <= ({w2,w1,w0} >> (8*off))[119:0], using mem_rdata for the final word.
  - When nw=2, w2 is treated as 0.
  - row_valid <= 1 -> HOLD.
  - Latency: row_valid rises 2 cycles after the last mem_rd cycle.
- HOLD: row_out and row_idx are stable while row_valid && !row_ready.
- Transfer occurs when row_valid && row_ready; row_valid drops the next cycle.
  - If row_idx < NUM_ROWS-1: row_idx += 1, base += FRAME_W_WORDS (mod 2^ADDR_W), -> FETCH. The next mem_rd is in the cycle after the transfer.
  - If row_idx == NUM_ROWS-1: done=1 for one cycle, busy=0, row_idx=0, -> IDLE. A start in that same done cycle is accepted.
- row_ready while row_valid=0 is ignored.
- No read overlap or prefetch. Per-row cycle count is nw+2 plus backpressure stalls.
- Reset mid-fetch: everything returns to reset values immediately. A memory response arriving after reset is ignored.
- Pixel ordering is little-end-first throughout, matching the interpolator's `currentPixels[8i +: 64]` indexing.

Test Plan:
Bench setup: FRAME_W_WORDS=4 (32-pixel-wide frame); memory pixel(x,y) = (x + 32y) mod 256.
1. Aligned window: start, blk_x=16, blk_y=2, row_ready=1 -> reads addr 10,11, then row 1 reads 14,15. Row 0 pixel k = 80+k (row_out[7:0]=80, [119:112]=94), row_idx=0. 15 rows total, done pulses once, busy drops the same cycle.
2. Unaligned window: blk_x=5, blk_y=0 -> off=5, three reads at addr 0,1,2. Row 0 pixels 5..19. row_valid rises exactly 2 cycles after the addr-2 read.
3. Two-word boundary: blk_x=9 -> off=1, two reads at addr 1,2. Pixels 9..23. Third word excluded.
4. Backpressure: blk_x=0, blk_y=0, row_ready=0 for 10 cycles during row 3 -> row_out, row_valid and row_idx=3 held stable. No mem_rd during the stall. Row 4 reads start the cycle after row_ready=1.
5. start while busy: pulse start with a different blk_x mid-window -> ignored; addresses continue the original sequence.
6. Reset mid-fetch: assert rst=0 during FETCH -> mem_rd, busy and row_valid go low immediately. After release, a new start (blk_x=16, blk_y=2) reproduces scenario 1 exactly.
